// File: rtl/rr_arbiter_8.sv
// ============================================================================
// rr_arbiter_8 -- 8-way round-robin arbiter with hold-until-release grants
//
// Purpose:
//    Grants one of eight level-sensitive requesters. Arbitration only happens
//    in IDLE. The winner is the first set request found searching upward from
//    the requester after the previous winner, wrapping from 7 to 0. A grant is
//    held while its request stays high. When the request drops there is one
//    grant-free IDLE cycle before the next arbitration. Requests are not
//    latched, so a pulse seen only during BUSY is never served.
//
// Configuration:
//    ARB_TIMEOUT_EN (macro) - when defined, a hold counter revokes a grant
//                             after MAX_HOLD consecutive cycles and pulses
//                             o_timeout for one cycle. When undefined, grants
//                             persist indefinitely and o_timeout is tied to 0.
//    MAX_HOLD (parameter)   - hold limit in cycles, legal range 2..255.
//
// Ports:
//    i_clk          in   1  sole clock, rising edge
//    i_rst          in   1  synchronous active-high reset
//    i_req          in   8  request lines, bit i = requester i
//    o_grant        out  8  registered one-hot grant, 8'h00 when idle
//    o_grant_idx    out  3  index of granted requester, 0 when no grant
//    o_grant_valid  out  1  high while a grant is asserted
//    o_timeout      out  1  one-cycle pulse when the hold limit revokes a grant
// ============================================================================
module rr_arbiter_8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_req,
   output logic [7:0] o_grant,
   output logic [2:0] o_grant_idx,
   output logic       o_grant_valid,
   output logic       o_timeout
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Elaboration-time range check on the hold limit
   generate
      if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
         $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Round-robin pick: first set bit searching upward from last+1, wrapping.
   // The 3-bit add wraps naturally; k=8 revisits 'last' itself, so the
   // previous winner is considered only after every other requester.
   // ------------------------------------------------------------------------
   function automatic logic [2:0] f_rr_pick(input logic [7:0] req,
                                            input logic [2:0] last);
      logic [2:0] pick;
      logic [2:0] idx;
      logic       found;
      pick  = 3'd0;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         idx = last + k[2:0];
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end else begin
            pick  = pick;
         end
      end
      return pick;
   endfunction

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t     r_state;
   logic [2:0] r_last;
   logic [2:0] r_grant_idx;
   logic       r_grant_valid;
   logic [7:0] r_grant;
   logic       r_timeout;

   // ------------------------------------------------------------------------
   // Combinational next values
   // ------------------------------------------------------------------------
   state_t     w_state_nxt;
   logic [2:0] w_last_nxt;
   logic [2:0] w_idx_nxt;
   logic       w_valid_nxt;
   logic [7:0] w_grant_nxt;
   logic       w_timeout_nxt;
   logic       w_any_req;
   logic       w_req_held;
   logic [2:0] w_winner;
   logic       w_expire;

   assign w_any_req  = |i_req;
   // Only meaningful in BUSY; in IDLE r_grant_idx is 0 and the value is unused
   assign w_req_held = i_req[r_grant_idx];
   assign w_winner   = f_rr_pick(i_req, r_last);

`ifdef ARB_TIMEOUT_EN
   // Terminal count: the counter reads 0 in the first BUSY cycle, so a value
   // of MAX_HOLD-1 means the grant has been visible for MAX_HOLD cycles.
   localparam logic [7:0] LP_HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] r_hold_cnt;
   logic [7:0] w_hold_cnt_nxt;

   assign w_expire = (r_state == ST_BUSY) && (r_hold_cnt == LP_HOLD_LAST);

   // Hold counter next value: cleared outside BUSY, counts while BUSY persists
   always_comb begin
      w_hold_cnt_nxt = 8'd0;
      if ((r_state == ST_BUSY) && (w_state_nxt == ST_BUSY)) begin
         w_hold_cnt_nxt = r_hold_cnt + 8'd1;
      end else begin
         w_hold_cnt_nxt = 8'd0;
      end
   end

   // Hold counter register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_cnt <= 8'd0;
      end else begin
         r_hold_cnt <= w_hold_cnt_nxt;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   // State register and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_last        <= 3'd7;
         r_grant_idx   <= 3'd0;
         r_grant_valid <= 1'b0;
         r_grant       <= 8'h00;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_last        <= w_last_nxt;
         r_grant_idx   <= w_idx_nxt;
         r_grant_valid <= w_valid_nxt;
         r_grant       <= w_grant_nxt;
         r_timeout     <= w_timeout_nxt;
      end
   end

   // Next-state logic: a dropped request wins over the hold limit, so a
   // requester releasing on its final allowed cycle gets no timeout pulse
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = ST_BUSY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!w_req_held) begin
               w_state_nxt = ST_IDLE;
            end else if (w_expire) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output next values: grant index/valid, priority pointer and timeout pulse
   always_comb begin
      w_idx_nxt     = 3'd0;
      w_valid_nxt   = 1'b0;
      w_last_nxt    = r_last;
      w_timeout_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_idx_nxt   = w_winner;
               w_valid_nxt = 1'b1;
               w_last_nxt  = w_winner;
            end else begin
               w_valid_nxt = 1'b0;
            end
         end
         ST_BUSY: begin
            if (w_req_held && !w_expire) begin
               w_idx_nxt   = r_grant_idx;
               w_valid_nxt = 1'b1;
            end else if (w_req_held) begin
               w_timeout_nxt = 1'b1;
            end else begin
               w_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // One-hot decode of the next grant index, zero when no grant
   always_comb begin
      w_grant_nxt = 8'h00;
      if (w_valid_nxt) begin
         w_grant_nxt = 8'h01 << w_idx_nxt;
      end else begin
         w_grant_nxt = 8'h00;
      end
   end

   assign o_grant       = r_grant;
   assign o_grant_idx   = r_grant_idx;
   assign o_grant_valid = r_grant_valid;
   assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle
// against a behavioural round-robin model.
module tb_rr_arbiter_8;

   localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   bit m_busy;
   int m_owner;
   int m_last;
   int m_held;
   bit m_tmo;

   always #5 clk = ~clk;

   rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req         (req),
      .o_grant       (grant),
      .o_grant_idx   (grant_idx),
      .o_grant_valid (grant_valid),
      .o_timeout     (timeout)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: what the outputs must be after this edge, from the current inputs
   task automatic model_update();
      bit found;
      int cand;
      m_tmo = 1'b0;
      if (rst) begin
         m_busy  = 1'b0;
         m_owner = 0;
         m_last  = 7;
         m_held  = 0;
      end else if (!m_busy) begin
         found = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            cand = (m_last + k) % 8;
            if (!found && req[cand]) begin
               found   = 1'b1;
               m_busy  = 1'b1;
               m_owner = cand;
               m_last  = cand;
               m_held  = 1;
            end
         end
      end else if (!req[m_owner]) begin
         m_busy = 1'b0;
      end else if (TMO_EN && (m_held >= MAX_HOLD)) begin
         m_busy = 1'b0;
         m_tmo  = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   // Compare all DUT outputs against the model, plus structural invariants
   task automatic compare_all();
      logic [7:0] e_grant;
      logic [7:0] e_idx;
      e_grant = m_busy ? (8'h01 << m_owner) : 8'h00;
      e_idx   = m_busy ? 8'(m_owner) : 8'h00;
      chk("grant",       grant, e_grant);
      chk("grant_idx",   {5'd0, grant_idx}, e_idx);
      chk("grant_valid", {7'd0, grant_valid}, {7'd0, m_busy});
      chk("timeout",     {7'd0, timeout}, {7'd0, m_tmo});
      chk("onehot0",     {7'd0, $onehot0(grant)}, 8'h01);
      chk("valid_or",    {7'd0, grant_valid}, {7'd0, |grant});
   endtask

   // One clock: inputs sampled at posedge, outputs checked at negedge
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 8'h00;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int r;
      rst = 1'b1;
      req = 8'h00;
      m_busy = 1'b0; m_owner = 0; m_last = 7; m_held = 0; m_tmo = 1'b0;

      // reset state
      do_reset();
      chk("rst_grant", grant, 8'h00);
      chk("rst_valid", {7'd0, grant_valid}, 8'h00);
      chk("rst_timeout", {7'd0, timeout}, 8'h00);

      // single request, one-cycle latency, release
      req = 8'h01; step();
      chk("r026_grant", grant, 8'h01);
      chk("r026_idx", {5'd0, grant_idx}, 8'h00);
      chk("r026_valid", {7'd0, grant_valid}, 8'h01);
      req = 8'h00; step();
      chk("r026_drop", grant, 8'h00);

      // all requesting, each grantee releases after 2 cycles
      do_reset();
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         step();
         chk("r027_idx", {5'd0, grant_idx}, 8'(i % 8));
         step();
         req = 8'hFF & ~(8'h01 << (i % 8));
         step();
         chk("r027_gap", {7'd0, grant_valid}, 8'h00);
         req = 8'hFF;
      end

      // wrap past 7 after a grant to 5
      do_reset();
      req = 8'h20; step();
      chk("r028_g5", {5'd0, grant_idx}, 8'h05);
      req = 8'h00; step();
      req = 8'h21; step();
      chk("r028_wrap0", {5'd0, grant_idx}, 8'h00);
      req = 8'h20; step();
      chk("r028_gap", grant, 8'h00);
      step();
      chk("r028_then5", {5'd0, grant_idx}, 8'h05);

      // reset while granted, then priority from 0
      do_reset();
      req = 8'h08; step();
      chk("r029_g3", grant, 8'h08);
      rst = 1'b1; req = 8'h88; step();
      chk("r029_rst_drop", grant, 8'h00);
      chk("r029_no_tmo", {7'd0, timeout}, 8'h00);
      rst = 1'b0; step();
      chk("r029_first3", {5'd0, grant_idx}, 8'h03);

      // hold limit
      do_reset();
      req = 8'h06;
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < MAX_HOLD; i++) begin
         step();
         chk("r030_hold1", {5'd0, grant_idx}, 8'h01);
         chk("r030_hold_valid", {7'd0, grant_valid}, 8'h01);
      end
      step();
      chk("r030_tmo", {7'd0, timeout}, 8'h01);
      chk("r030_revoked", grant, 8'h00);
      step();
      chk("r030_tmo_pulse", {7'd0, timeout}, 8'h00);
      chk("r030_next2", {5'd0, grant_idx}, 8'h02);
`else
      for (int i = 0; i < 20; i++) begin
         step();
         chk("r030_hold1", {5'd0, grant_idx}, 8'h01);
         chk("r030_no_tmo", {7'd0, timeout}, 8'h00);
      end
`endif

      // randomized phase
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         r = $urandom_range(0, 9);
         if (r < 3) begin
            req = 8'($urandom_range(0, 255));
         end else if (r == 3) begin
            req = 8'h00;
         end else if (r == 4) begin
            req = req & ~(8'h01 << m_owner);
         end else if (r == 5) begin
            req = req | (8'h01 << $urandom_range(0, 7));
         end
         rst = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive cycles one grant may be held when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  8  request lines; bit i is requester i, level-sensitive.
REQ-005 grant  output  8  one-hot grant; registered; all zeros when no grant.
REQ-006 grant_idx  output  3  binary index of the granted requester; 0 when grant_valid is low.
REQ-007 grant_valid  output  1  high while any grant is asserted.
REQ-008 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit; constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-009 The module SHALL implement the states IDLE and BUSY.
REQ-010 grant SHALL always equal the 3:8 one-hot decode of grant_idx when grant_valid=1, and 8'h00 otherwise.
REQ-011 In IDLE with req=0, the state SHALL remain IDLE with all outputs zero.
REQ-012 In IDLE with req!=0, the winner SHALL be the first set req bit searching upward from (last+1) mod 8 with wrap-around from 7 to 0.
REQ-013 Grant latency SHALL be one cycle: on the edge after the IDLE arbitration cycle, the state SHALL be BUSY, grant_idx SHALL be the winner, grant_valid SHALL be 1, and last SHALL be set to the winner.
REQ-014 In BUSY, the grant SHALL hold unchanged while req[grant_idx]=1, regardless of other req bits.
REQ-015 In BUSY with req[grant_idx]=0, the next state SHALL be IDLE with the grant deasserted on that edge, leaving exactly one grant-free cycle before any new grant.
REQ-016 A requester that drops req in the same cycle that another raises it SHALL NOT affect the above; the new requester is arbitrated in the following IDLE cycle.
REQ-017 Once a requester is granted, it SHALL have the lowest priority at the next arbitration, so no requester can win twice while another is continuously requesting.
REQ-018 Requests that are raised and dropped entirely within BUSY SHALL be ignored, with no latching of requests.

Reset
REQ-019 While rst=1 at a clock edge: state=IDLE, grant=8'h00, grant_idx=0, grant_valid=0, timeout=0, hold counter=0, last=7, so requester 0 has top priority after reset.
REQ-020 Assertion of rst in BUSY SHALL drop the grant on that same edge, with no timeout pulse.
REQ-021 The first arbitration after reset SHALL occur in the first cycle with rst=0.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: a hold counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-023 When the granted requester has held BUSY for MAX_HOLD cycles with req[grant_idx] still 1, the next edge SHALL force IDLE, drop the grant and pulse timeout for exactly one cycle.
REQ-024 After a timeout, the revoked requester SHALL follow normal round-robin, re-winning only if no other requester is active.
REQ-025 Macro ARB_TIMEOUT_EN undefined: there SHALL be no hold counter, timeout SHALL be tied to 0, and a grant SHALL persist indefinitely while its req is held.

Verification
REQ-026 Reset, then req=8'h01 at cycle 0 -> grant=8'h01, grant_idx=0, grant_valid=1 at cycle 1; drop req -> grant=8'h00 at the next edge.
REQ-027 req=8'hFF held, each grantee releasing after 2 cycles -> grant_idx sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-028 After a grant to 5 and its release, req=8'h21 -> grant_idx=0 (wrap past 7), then grant_idx=5 after 0 releases.
REQ-029 rst asserted while grant=8'h08 -> grant=8'h00 at the same edge; with req=8'h88 held after reset, grant_idx=3 first.
REQ-030 ARB_TIMEOUT_EN with MAX_HOLD=4, req=8'h06 held -> requester 1 granted for 4 cycles, timeout pulse, requester 2 granted after the idle cycle; without the macro -> requester 1 held indefinitely and timeout stays 0.
REQ-031 All runs -> a checker SHALL confirm every cycle that grant is one-hot or zero and that grant_valid = |grant.
